// File: rtl/ct_had_event_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ct_had_event_pkg
//  Description : Shared constants for the debug cross-trigger matrix. It holds
//                the broadcast-channel state encoding and the channel-id /
//                polarity constants.
//  Revision    : 1.0  initial release
// ============================================================================
package ct_had_event_pkg;

    // Broadcast channel states
    typedef logic [1:0] chan_state_t;
    localparam chan_state_t ST_IDLE = 2'd0;
    localparam chan_state_t ST_HOLD = 2'd1;
    localparam chan_state_t ST_WAIT = 2'd2;

    // Channel ids. Each id also sets the channel's polarity:
    // ENTER waits for dbgon=1 and EXIT waits for dbgon=0.
    localparam logic CH_ENTER = 1'b0;
    localparam logic CH_EXIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ct_had_event_matrix_if.sv
`default_nettype none
// ============================================================================
//  Module      : ct_had_event_matrix_if
//  Description : Core-side event bundle between the cross-trigger matrix and
//                the cores of the cluster.
//                  core_enter_req_o / core_exit_req_o : per-core debug events
//                  core_dbgon                         : per-core debug status
//                  core_enter_req_i / core_exit_req_i : requests to each core
//                The master modport is the matrix. The slave modport is the
//                core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ct_had_event_matrix_if #(
    parameter int CORE_NUM = 4
);
    logic [CORE_NUM-1:0] core_enter_req_o;
    logic [CORE_NUM-1:0] core_exit_req_o;
    logic [CORE_NUM-1:0] core_dbgon;
    logic [CORE_NUM-1:0] core_enter_req_i;
    logic [CORE_NUM-1:0] core_exit_req_i;

    modport master (
        input  core_enter_req_o,
        input  core_exit_req_o,
        input  core_dbgon,
        output core_enter_req_i,
        output core_exit_req_i
    );

    modport slave (
        output core_enter_req_o,
        output core_exit_req_o,
        output core_dbgon,
        input  core_enter_req_i,
        input  core_exit_req_i
    );
endinterface
`default_nettype wire

// File: rtl/ct_had_event_matrix_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ct_had_event_chan
//  Description : One broadcast channel (halt or resume) of the matrix.
//                It runs IDLE -> HOLD -> WAIT -> IDLE. It holds the registered
//                target mask that drives the requests to the cores and the
//                launch counter that sets hold time and timeout.
//                Ports:
//                  clk, rst_n  : clock, async active-low reset
//                  i_launch    : launch attempt (only honoured in IDLE)
//                  i_grp       : group membership mask
//                  i_excl      : originators, excluded from the targets
//                  i_dbgon     : per-core debug status
//                  i_abort     : drop the broadcast immediately, no timeout
//                  o_req       : per-core request level
//                  o_busy      : channel not IDLE
//                  o_timeout   : 1-cycle pulse when the broadcast is abandoned
//  Revision    : 1.0  initial release
// ============================================================================
module ct_had_event_chan
    import ct_had_event_pkg::*;
#(
    parameter int   CORE_NUM = 4,
    parameter int   HOLD_CYC = 4,
    parameter int   TIMEOUT  = 255,
    parameter logic POL      = CH_ENTER
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_launch,
    input  wire logic [CORE_NUM-1:0] i_grp,
    input  wire logic [CORE_NUM-1:0] i_excl,
    input  wire logic [CORE_NUM-1:0] i_dbgon,
    input  wire logic                i_abort,
    output logic      [CORE_NUM-1:0] o_req,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int          CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] C_TO_LAST   = CW'(TIMEOUT - 1);

    chan_state_t         r_state;
    logic [CW-1:0]       r_cnt;
    logic [CORE_NUM-1:0] r_tgt;
    logic                r_timeout;

    logic [CORE_NUM-1:0] w_unresp;
    logic [CORE_NUM-1:0] w_launch_tgt;
    logic [CORE_NUM-1:0] w_left;

    // A core "has not responded" while its dbgon still differs from the
    // state this channel is driving it toward.
    assign w_unresp     = (POL == CH_ENTER) ? ~i_dbgon : i_dbgon;
    assign w_launch_tgt = i_grp & ~i_excl & w_unresp;
    assign w_left       = r_tgt & w_unresp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_tgt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // With an empty target set nothing is sent and the
                        // channel stays idle.
                        if (i_launch && (|w_launch_tgt)) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                            r_tgt   <= w_launch_tgt;
                        end
                    end
                    ST_HOLD: begin
                        // Keep the level up long enough for the core's
                        // 2-flop synchronizer, whatever dbgon does meanwhile.
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_HOLD_LAST) begin
                            r_state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_left == '0) begin
                            // Completion takes priority over a timeout in the
                            // same cycle.
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_tgt   <= '0;
                        end else if (r_cnt == C_TO_LAST) begin
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                            r_tgt     <= '0;
                            r_timeout <= 1'b1;
                        end else begin
                            // Release the cores that have already responded.
                            r_tgt <= w_left;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_tgt   <= '0;
                    end
                endcase
            end
        end
    end

    // r_tgt is zero whenever the channel is idle, so it drives the outputs directly.
    assign o_req     = r_tgt;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: rtl/ct_had_event_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : ct_had_event_matrix
//  Description : Cluster cross-trigger matrix for debug halt/resume groups.
//                A core's enter (exit) event halts (resumes) the other members
//                of its group. Requests are held as levels and released once
//                the targets respond.
//                Ports:
//                  cpuclk, cpurst_b : cluster clock, async active-low reset
//                  cfg_matrix_en    : allow new broadcasts to launch
//                  cfg_enter_grp    : halt group membership
//                  cfg_exit_grp     : resume group membership
//                  cif (master)     : per-core events, status and requests
//                  matrix_busy      : any channel active or an exit pending
//                  matrix_timeout   : 1-cycle pulse on an abandoned broadcast
//  Revision    : 1.0  initial release
// ============================================================================
module ct_had_event_matrix
    import ct_had_event_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int HOLD_CYC = 4,
    parameter int TIMEOUT  = 255
) (
    input  wire logic                cpuclk,
    input  wire logic                cpurst_b,
    input  wire logic                cfg_matrix_en,
    input  wire logic [CORE_NUM-1:0] cfg_enter_grp,
    input  wire logic [CORE_NUM-1:0] cfg_exit_grp,
    ct_had_event_matrix_if.master    cif,
    output logic                     matrix_busy,
    output logic                     matrix_timeout
);

    logic [CORE_NUM-1:0] r_enter_q;
    logic [CORE_NUM-1:0] r_exit_q;
    logic                r_exit_pend;
    logic [CORE_NUM-1:0] r_exit_pend_vec;

    logic [CORE_NUM-1:0] w_rise_enter;
    logic [CORE_NUM-1:0] w_rise_exit;
    logic [CORE_NUM-1:0] w_exit_vec;
    logic                w_enter_busy;
    logic                w_exit_busy;
    logic                w_enter_try;
    logic                w_exit_go;
    logic                w_exit_abort;
    logic                w_enter_to;
    logic                w_exit_to;

    assign w_rise_enter = cif.core_enter_req_o & ~r_enter_q & cfg_enter_grp;
    assign w_rise_exit  = cif.core_exit_req_o  & ~r_exit_q  & cfg_exit_grp;

    // Halt has priority: a halt launch preempts any resume activity.
    assign w_enter_try  = cfg_matrix_en & ~w_enter_busy & (|w_rise_enter);
    assign w_exit_abort = w_enter_try & w_exit_busy;

    // A resume launches only when the halt side is quiet for this edge.
    // A pending resume carries its originators, plus any fresh rise.
    assign w_exit_go  = cfg_matrix_en & ~w_enter_busy & ~w_exit_busy & ~w_enter_try
                      & (r_exit_pend | (|w_rise_exit));
    assign w_exit_vec = r_exit_pend_vec | w_rise_exit;

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            // The history starts all-ones. An event line that is already high
            // when reset is released then does not count as a new event.
            r_enter_q       <= '1;
            r_exit_q        <= '1;
            r_exit_pend     <= 1'b0;
            r_exit_pend_vec <= '0;
        end else begin
            r_enter_q <= cif.core_enter_req_o;
            r_exit_q  <= cif.core_exit_req_o;
            if (w_exit_go) begin
                r_exit_pend     <= 1'b0;
                r_exit_pend_vec <= '0;
            end else if ((|w_rise_exit) && (w_enter_busy || w_enter_try)) begin
                r_exit_pend     <= 1'b1;
                r_exit_pend_vec <= r_exit_pend_vec | w_rise_exit;
            end
        end
    end

    ct_had_event_chan #(
        .CORE_NUM (CORE_NUM),
        .HOLD_CYC (HOLD_CYC),
        .TIMEOUT  (TIMEOUT),
        .POL      (CH_ENTER)
    ) u_enter_chan (
        .clk       (cpuclk),
        .rst_n     (cpurst_b),
        .i_launch  (w_enter_try),
        .i_grp     (cfg_enter_grp),
        .i_excl    (w_rise_enter),
        .i_dbgon   (cif.core_dbgon),
        .i_abort   (1'b0),
        .o_req     (cif.core_enter_req_i),
        .o_busy    (w_enter_busy),
        .o_timeout (w_enter_to)
    );

    ct_had_event_chan #(
        .CORE_NUM (CORE_NUM),
        .HOLD_CYC (HOLD_CYC),
        .TIMEOUT  (TIMEOUT),
        .POL      (CH_EXIT)
    ) u_exit_chan (
        .clk       (cpuclk),
        .rst_n     (cpurst_b),
        .i_launch  (w_exit_go),
        .i_grp     (cfg_exit_grp),
        .i_excl    (w_exit_vec),
        .i_dbgon   (cif.core_dbgon),
        .i_abort   (w_exit_abort),
        .o_req     (cif.core_exit_req_i),
        .o_busy    (w_exit_busy),
        .o_timeout (w_exit_to)
    );

    assign matrix_busy    = w_enter_busy | w_exit_busy | r_exit_pend;
    assign matrix_timeout = w_enter_to | w_exit_to;

    // No core may be asked to halt and resume at the same time.
    a_req_mutex: assert property (@(posedge cpuclk) disable iff (!cpurst_b)
        ((cif.core_enter_req_i & cif.core_exit_req_i) == '0));

endmodule
`default_nettype wire

// File: tb/tb_ct_had_event_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ct_had_event_matrix
//  Description : Scoreboard bench for ct_had_event_matrix. Directed scenarios
//                are followed by randomized traffic. A broadcast-level
//                reference model predicts the outputs of every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ct_had_event_matrix;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int TO   = 255;

    logic         cpuclk   = 1'b0;
    logic         cpurst_b = 1'b0;
    logic         cfg_en   = 1'b0;
    logic [N-1:0] grp_en   = '1;
    logic [N-1:0] grp_ex   = '1;
    logic         matrix_busy;
    logic         matrix_timeout;

    ct_had_event_matrix_if #(.CORE_NUM(N)) cif();

    ct_had_event_matrix #(
        .CORE_NUM (N),
        .HOLD_CYC (HOLD),
        .TIMEOUT  (TO)
    ) dut (
        .cpuclk         (cpuclk),
        .cpurst_b       (cpurst_b),
        .cfg_matrix_en  (cfg_en),
        .cfg_enter_grp  (grp_en),
        .cfg_exit_grp   (grp_ex),
        .cif            (cif),
        .matrix_busy    (matrix_busy),
        .matrix_timeout (matrix_timeout)
    );

    always #5 cpuclk = ~cpuclk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (one broadcast per channel) ----------
    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] ex;
        logic         busy;
        logic         to;
    } exp_t;
    exp_t q[$];

    bit           m_e_act, m_x_act, m_pend;
    int           m_e_age, m_x_age;
    logic [N-1:0] m_e_tgt, m_x_tgt, m_pend_vec;
    logic [N-1:0] m_prev_en = '1;
    logic [N-1:0] m_prev_ex = '1;

    // age counts edges since the launch. The first HOLD edges are pure hold.
    // After that the broadcast ends once every target has responded, or it
    // is abandoned on its (TO)th edge.
    task automatic advance(inout bit act, inout int age, inout logic [N-1:0] tgt,
                           input logic [N-1:0] unresp, inout bit to);
        if (age < HOLD) begin
            age++;
        end else if ((tgt & unresp) == '0) begin
            act = 0; tgt = '0;
        end else if (age == TO - 1) begin
            act = 0; tgt = '0; to = 1;
        end else begin
            tgt = tgt & unresp; age++;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] re, rx, vec, t, dbg;
        bit e_was, x_was, try_e, go_x, to;
        exp_t e;
        to = 0;
        dbg = cif.core_dbgon;
        if (!cpurst_b) begin
            m_e_act = 0; m_x_act = 0; m_pend = 0;
            m_e_tgt = '0; m_x_tgt = '0; m_pend_vec = '0;
            m_prev_en = '1; m_prev_ex = '1;
        end else begin
            re = cif.core_enter_req_o & ~m_prev_en & grp_en;
            rx = cif.core_exit_req_o  & ~m_prev_ex & grp_ex;
            m_prev_en = cif.core_enter_req_o;
            m_prev_ex = cif.core_exit_req_o;
            e_was = m_e_act;
            x_was = m_x_act;
            try_e = cfg_en && !e_was && (re != '0);
            if (e_was) advance(m_e_act, m_e_age, m_e_tgt, ~dbg, to);
            if (x_was) begin
                if (try_e) begin m_x_act = 0; m_x_tgt = '0; end
                else advance(m_x_act, m_x_age, m_x_tgt, dbg, to);
            end
            if (try_e) begin
                t = grp_en & ~re & ~dbg;
                if (t != '0) begin m_e_act = 1; m_e_age = 0; m_e_tgt = t; end
            end
            go_x = cfg_en && !e_was && !x_was && !try_e && (m_pend || rx != '0);
            if (go_x) begin
                vec = m_pend_vec | rx;
                t = grp_ex & ~vec & dbg;
                if (t != '0) begin m_x_act = 1; m_x_age = 0; m_x_tgt = t; end
                m_pend = 0; m_pend_vec = '0;
            end else if (rx != '0 && (e_was || try_e)) begin
                m_pend = 1; m_pend_vec = m_pend_vec | rx;
            end
        end
        e.en   = m_e_tgt;
        e.ex   = m_x_tgt;
        e.busy = m_e_act | m_x_act | m_pend;
        e.to   = to;
        q.push_back(e);
    endtask

    // ---------------- monitor --------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge cpuclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_enter_req_i", 8'(cif.core_enter_req_i), 8'(e.en));
                check("sb_exit_req_i",  8'(cif.core_exit_req_i),  8'(e.ex));
                check("sb_busy",        8'(matrix_busy),          8'(e.busy));
                check("sb_timeout",     8'(matrix_timeout),       8'(e.to));
            end
        end
    end

    // ---------------- driver ---------------------------------------------
    // Every call predicts the next edge, then moves on to the next falling edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge cpuclk);
        end
    endtask

    task automatic set_in(input logic [N-1:0] en, input logic [N-1:0] ex, input logic [N-1:0] dbg);
        cif.core_enter_req_o = en;
        cif.core_exit_req_o  = ex;
        cif.core_dbgon       = dbg;
    endtask

    initial begin
        int pulses;
        set_in('0, '0, '0);
        @(negedge cpuclk);
        step(2);
        cpurst_b = 1'b1;
        cfg_en   = 1'b1;
        step(2);
        check("reset_enter_idle", 8'(cif.core_enter_req_i), 8'h0);
        check("reset_busy_idle",  8'(matrix_busy), 8'h0);

        // Core0 halt event fans out to cores 1-3, then a resume event.
        set_in(4'b0001, '0, '0);        step();
        check("t1_launch", 8'(cif.core_enter_req_i), 8'h0e);
        step(4);
        check("t1_hold", 8'(cif.core_enter_req_i), 8'h0e);
        set_in(4'b0001, '0, 4'b1111);   step();
        check("t1_release", 8'(cif.core_enter_req_i), 8'h00);
        set_in('0, 4'b0001, 4'b1111);   step();
        check("t1_exit_launch", 8'(cif.core_exit_req_i), 8'h0e);
        step(4);
        set_in('0, 4'b0001, '0);        step(3);

        // A non-member event is ignored. A member event reaches the other member only.
        grp_en = 4'b0011;
        set_in(4'b0100, '0, '0);        step();
        check("t2_nonmember", 8'(cif.core_enter_req_i), 8'h00);
        check("t2_nonmember_busy", 8'(matrix_busy), 8'h0);
        set_in(4'b0110, '0, '0);        step();
        check("t2_member", 8'(cif.core_enter_req_i), 8'h01);
        set_in(4'b0110, '0, 4'b0001);   step(8);
        set_in('0, '0, '0);             step(2);

        // Core3 never halts: cores 1-2 release early, then a single timeout.
        grp_en = 4'b1111;
        pulses = 0;
        set_in(4'b0001, '0, '0);        step();
        for (int i = 0; i < 260; i++) begin
            if (i == 10) cif.core_dbgon = 4'b0110;
            if (i == 20) check("t3_partial", 8'(cif.core_enter_req_i), 8'h08);
            step();
            if (matrix_timeout) pulses++;
        end
        check("t3_timeout_pulses", 8'(pulses), 8'd1);
        check("t3_after_timeout", 8'(cif.core_enter_req_i), 8'h00);

        // A halt event in the middle of a resume broadcast aborts the resume.
        set_in('0, '0, 4'b1111);        step(2);
        set_in('0, 4'b0001, 4'b1111);   step(6);
        check("t4_exit_wait", 8'(cif.core_exit_req_i), 8'h0e);
        set_in(4'b0010, 4'b0001, 4'b1011); step();
        check("t4_exit_aborted", 8'(cif.core_exit_req_i), 8'h00);
        check("t4_enter_launch", 8'(cif.core_enter_req_i), 8'h04);
        check("t4_no_timeout", 8'(matrix_timeout), 8'h0);
        set_in(4'b0010, 4'b0001, 4'b1111); step(6);

        // Simultaneous halt and resume events: resume follows the halt.
        set_in('0, '0, '0);             step(2);
        set_in(4'b0001, 4'b0001, '0);   step();
        check("t5_enter_first", 8'(cif.core_enter_req_i), 8'h0e);
        check("t5_exit_held", 8'(cif.core_exit_req_i), 8'h00);
        step(4);
        cif.core_dbgon = 4'b1111;       step();
        check("t5_gap_exit", 8'(cif.core_exit_req_i), 8'h00);
        check("t5_gap_busy", 8'(matrix_busy), 8'h1);
        step();
        check("t5_exit_launch", 8'(cif.core_exit_req_i), 8'h0e);
        cif.core_dbgon = '0;            step(6);
        check("t5_idle", 8'(matrix_busy), 8'h0);

        // Async reset mid-hold. An event line held high afterwards is not a new event.
        set_in('0, '0, '0);             step();
        set_in(4'b0001, '0, '0);        step(2);
        #2 cpurst_b = 1'b0;
        #1;
        check("t6_async_enter", 8'(cif.core_enter_req_i), 8'h00);
        check("t6_async_busy", 8'(matrix_busy), 8'h0);
        step(2);
        cpurst_b = 1'b1;
        step(3);
        check("t6_no_event", 8'(cif.core_enter_req_i), 8'h00);
        check("t6_no_busy", 8'(matrix_busy), 8'h0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) cif.core_enter_req_o[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(7) == 0) cif.core_exit_req_o[$urandom_range(N-1)]  ^= 1'b1;
            if ($urandom_range(5) == 0) cif.core_dbgon[$urandom_range(N-1)]       ^= 1'b1;
            if ($urandom_range(63) == 0) grp_en = N'($urandom);
            if ($urandom_range(63) == 0) grp_ex = N'($urandom);
            cfg_en = ($urandom_range(15) != 0);
            step();
        end

        @(posedge cpuclk);
        #2;
        check("queue_drained", 8'(q.size()), 8'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
